// File: rtl/obuf_arb.sv
// obuf_arb: round-robin 5:1 output arbiter feeding a 2-entry FIFO.
// Grant is combinational; ready/valid decode registered state only.
`ifndef PKT_W
`define PKT_W 8
`endif
`ifndef DIR_N
`define DIR_N 0
`endif
`ifndef DIR_S
`define DIR_S 1
`endif
`ifndef DIR_E
`define DIR_E 2
`endif
`ifndef DIR_W
`define DIR_W 3
`endif
`ifndef DIR_B
`define DIR_B 4
`endif

module obuf_arb #(
  parameter int PYLD_W = `PKT_W,
  parameter int DEPTH  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          arb_req,
  input  logic [5*PYLD_W-1:0] payload_i,
  output logic [4:0]          arb_gnt,
  output logic                obuf_rdy,
  output logic                obuf_vld,
  output logic [PYLD_W-1:0]   payload_o,
  input  logic                ds_rdy
);

  logic [2:0]        r_ptr;
  logic [1:0]        r_cnt;
  logic              r_head;
  logic              r_tail;
  logic [PYLD_W-1:0] r_mem [2];

  logic [3:0]        w_k;
  logic [2:0]        w_idx;
  logic              w_any;
  logic [2:0]        w_nptr;
  logic [PYLD_W-1:0] w_sel;
  logic              w_push;
  logic              w_pop;

  // Rotating first-set search starting at the round-robin pointer.
  always_comb begin
    w_k   = '0;
    w_idx = '0;
    w_any = 1'b0;
    for (int i = 0; i < 5; i++) begin
      w_k = {1'b0, r_ptr} + 4'(i);
      if (w_k >= 4'd5)
        w_k = w_k - 4'd5;
      if (!w_any && arb_req[w_k[2:0]]) begin
        w_any = 1'b1;
        w_idx = w_k[2:0];
      end
    end
  end

  assign arb_gnt   = w_any ? (5'b00001 << w_idx) : 5'b00000;
  assign w_nptr    = (w_idx == 3'd4) ? 3'd0 : w_idx + 3'd1;
  assign w_sel     = payload_i[w_idx*PYLD_W +: PYLD_W];

  assign obuf_rdy  = (r_cnt < 2'(DEPTH));
  assign obuf_vld  = (r_cnt != 2'd0);
  assign payload_o = r_mem[r_head];

  assign w_push    = w_any && obuf_rdy;
  assign w_pop     = obuf_vld && ds_rdy;

  // FIFO storage, pointers, occupancy and arbitration pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr    <= '0;
      r_cnt    <= '0;
      r_head   <= 1'b0;
      r_tail   <= 1'b0;
      r_mem[0] <= '0;
      r_mem[1] <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_tail] <= w_sel;
        r_tail        <= ~r_tail;
        r_ptr         <= w_nptr;
      end
      if (w_pop)
        r_head <= ~r_head;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_obuf_arb.sv
// tb_obuf_arb: directed scenarios for obuf_arb with a payload
// scoreboard queue filled on push stimulus and drained on pops.
`timescale 1ns/1ps

module tb_obuf_arb;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4:0]     arb_req;
  logic [5*W-1:0] payload_i;
  logic [4:0]     arb_gnt;
  logic           obuf_rdy;
  logic           obuf_vld;
  logic [W-1:0]   payload_o;
  logic           ds_rdy;

  int             n_tests = 0;
  int             n_fail  = 0;
  logic [W-1:0]   q[$];
  logic [W-1:0]   exp_pl;

  obuf_arb #(.PYLD_W(W), .DEPTH(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .arb_req   (arb_req),
    .payload_i (payload_i),
    .arb_gnt   (arb_gnt),
    .obuf_rdy  (obuf_rdy),
    .obuf_vld  (obuf_vld),
    .payload_o (payload_o),
    .ds_rdy    (ds_rdy)
  );

  always #5 clk = ~clk;

  task automatic set_pl(input int k, input logic [W-1:0] v);
    payload_i[k*W +: W] = v;
  endtask

  task automatic drv_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic pop_exp();
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL sb_empty got queue size 0 exp >0");
      exp_pl = '0;
    end else begin
      exp_pl = q.pop_front();
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    arb_req   = 5'b0;
    payload_i = '0;
    ds_rdy    = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obuf_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_vld got %b exp 0", obuf_vld);
    end
    n_tests++;
    if (payload_o !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_pl got %h exp 00", payload_o);
    end
    n_tests++;
    if (obuf_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_rdy got %b exp 1", obuf_rdy);
    end
    n_tests++;
    if (arb_gnt !== 5'b00000) begin
      n_fail++;
      $display("FAIL rst_gnt0 got %b exp 00000", arb_gnt);
    end
    arb_req = 5'b10110;
    #1;
    n_tests++;
    if (arb_gnt !== 5'b00010) begin
      n_fail++;
      $display("FAIL rst_gnt got %b exp 00010", arb_gnt);
    end
    drv_edge();
    arb_req = 5'b0;
    drv_edge();
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obuf_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL rel_vld got %b exp 0", obuf_vld);
    end
  endtask

  task automatic test_single();
    drv_edge();
    arb_req = 5'b00100;
    set_pl(2, 8'hA5);
    ds_rdy = 1'b1;
    q.push_back(8'hA5);
    @(negedge clk);
    n_tests++;
    if (arb_gnt !== 5'b00100) begin
      n_fail++;
      $display("FAIL single_gnt got %b exp 00100", arb_gnt);
    end
    n_tests++;
    if (obuf_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL single_vld0 got %b exp 0", obuf_vld);
    end
    drv_edge();
    arb_req = 5'b0;
    @(negedge clk);
    n_tests++;
    if (arb_gnt !== 5'b00000) begin
      n_fail++;
      $display("FAIL single_gnt_off got %b exp 00000", arb_gnt);
    end
    n_tests++;
    if (obuf_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL single_vld got %b exp 1", obuf_vld);
    end
    pop_exp();
    n_tests++;
    if (payload_o !== exp_pl) begin
      n_fail++;
      $display("FAIL single_pl got %h exp %h", payload_o, exp_pl);
    end
    drv_edge();
    arb_req = 5'b10001;
    set_pl(0, 8'h40);
    set_pl(4, 8'h44);
    q.push_back(8'h44);
    @(negedge clk);
    n_tests++;
    if (arb_gnt !== 5'b10000) begin
      n_fail++;
      $display("FAIL ptr3_gnt got %b exp 10000", arb_gnt);
    end
    drv_edge();
    arb_req = 5'b0;
    @(negedge clk);
    pop_exp();
    n_tests++;
    if (payload_o !== exp_pl) begin
      n_fail++;
      $display("FAIL ptr3_pl got %h exp %h", payload_o, exp_pl);
    end
    drv_edge();
  endtask

  task automatic test_round_robin();
    logic [4:0] eg;
    for (int k = 0; k < 5; k++)
      set_pl(k, 8'h10 + 8'(k));
    ds_rdy = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        drv_edge();
        arb_req = 5'b11111;
      end else begin
        drv_edge();
      end
      eg = 5'b00001 << (i % 5);
      q.push_back(8'h10 + 8'(i % 5));
      @(negedge clk);
      n_tests++;
      if (arb_gnt !== eg) begin
        n_fail++;
        $display("FAIL rr_gnt%0d got %b exp %b", i, arb_gnt, eg);
      end
      if (i > 0) begin
        pop_exp();
        n_tests++;
        if (payload_o !== exp_pl) begin
          n_fail++;
          $display("FAIL rr_pl%0d got %h exp %h", i, payload_o, exp_pl);
        end
      end
    end
    drv_edge();
    arb_req = 5'b0;
    @(negedge clk);
    pop_exp();
    n_tests++;
    if (payload_o !== exp_pl) begin
      n_fail++;
      $display("FAIL rr_last got %h exp %h", payload_o, exp_pl);
    end
    drv_edge();
  endtask

  task automatic test_backpressure();
    logic [4:0] eg [4];
    logic       er [4];
    eg[0] = 5'b00010; er[0] = 1'b1;
    eg[1] = 5'b00100; er[1] = 1'b1;
    eg[2] = 5'b00001; er[2] = 1'b0;
    eg[3] = 5'b00001; er[3] = 1'b0;
    drv_edge();
    ds_rdy  = 1'b0;
    arb_req = 5'b00111;
    set_pl(0, 8'hA0);
    set_pl(1, 8'hA1);
    set_pl(2, 8'hA2);
    q.push_back(8'hA1);
    q.push_back(8'hA2);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_tests++;
      if (arb_gnt !== eg[c]) begin
        n_fail++;
        $display("FAIL bp_gnt%0d got %b exp %b", c, arb_gnt, eg[c]);
      end
      n_tests++;
      if (obuf_rdy !== er[c]) begin
        n_fail++;
        $display("FAIL bp_rdy%0d got %b exp %b", c, obuf_rdy, er[c]);
      end
      if (c > 0) begin
        n_tests++;
        if (payload_o !== 8'hA1) begin
          n_fail++;
          $display("FAIL bp_pl%0d got %h exp a1", c, payload_o);
        end
      end
      drv_edge();
    end
  endtask

  task automatic test_drain();
    ds_rdy = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obuf_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain_rdy0 got %b exp 0", obuf_rdy);
    end
    pop_exp();
    n_tests++;
    if (payload_o !== exp_pl) begin
      n_fail++;
      $display("FAIL drain_pl0 got %h exp %h", payload_o, exp_pl);
    end
    drv_edge();
    q.push_back(8'hA0);
    @(negedge clk);
    n_tests++;
    if (obuf_rdy !== 1'b1 || arb_gnt !== 5'b00001) begin
      n_fail++;
      $display("FAIL drain_push got rdy=%b gnt=%b exp rdy=1 gnt=00001",
               obuf_rdy, arb_gnt);
    end
    pop_exp();
    n_tests++;
    if (payload_o !== exp_pl) begin
      n_fail++;
      $display("FAIL drain_pl1 got %h exp %h", payload_o, exp_pl);
    end
    drv_edge();
    arb_req = 5'b0;
    @(negedge clk);
    pop_exp();
    n_tests++;
    if (obuf_vld !== 1'b1 || payload_o !== exp_pl) begin
      n_fail++;
      $display("FAIL drain_pl2 got vld=%b %h exp vld=1 %h",
               obuf_vld, payload_o, exp_pl);
    end
    drv_edge();
    ds_rdy = 1'b0;
  endtask

  task automatic test_push_pop();
    arb_req = 5'b00010;
    set_pl(1, 8'hB1);
    q.push_back(8'hB1);
    @(negedge clk);
    n_tests++;
    if (arb_gnt !== 5'b00010) begin
      n_fail++;
      $display("FAIL pp_gnt0 got %b exp 00010", arb_gnt);
    end
    drv_edge();
    arb_req = 5'b00100;
    set_pl(2, 8'hB2);
    ds_rdy  = 1'b1;
    q.push_back(8'hB2);
    @(negedge clk);
    n_tests++;
    if (arb_gnt !== 5'b00100 || obuf_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_gnt1 got gnt=%b rdy=%b exp gnt=00100 rdy=1",
               arb_gnt, obuf_rdy);
    end
    pop_exp();
    n_tests++;
    if (payload_o !== exp_pl) begin
      n_fail++;
      $display("FAIL pp_pl0 got %h exp %h", payload_o, exp_pl);
    end
    drv_edge();
    arb_req = 5'b0;
    ds_rdy  = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obuf_vld !== 1'b1 || obuf_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_cnt1 got vld=%b rdy=%b exp vld=1 rdy=1",
               obuf_vld, obuf_rdy);
    end
    pop_exp();
    n_tests++;
    if (payload_o !== exp_pl) begin
      n_fail++;
      $display("FAIL pp_pl1 got %h exp %h", payload_o, exp_pl);
    end
    drv_edge();
    ds_rdy = 1'b1;
    drv_edge();
    ds_rdy = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obuf_vld !== 1'b0 || obuf_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL pp_empty got vld=%b rdy=%b exp vld=0 rdy=1",
               obuf_vld, obuf_rdy);
    end
  endtask

  task automatic test_mid_reset();
    drv_edge();
    arb_req = 5'b01100;
    set_pl(2, 8'hC2);
    set_pl(3, 8'hC3);
    @(negedge clk);
    n_tests++;
    if (arb_gnt !== 5'b01000) begin
      n_fail++;
      $display("FAIL mr_gnt0 got %b exp 01000", arb_gnt);
    end
    drv_edge();
    drv_edge();
    @(negedge clk);
    n_tests++;
    if (obuf_rdy !== 1'b0 || obuf_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL mr_full got rdy=%b vld=%b exp rdy=0 vld=1",
               obuf_rdy, obuf_vld);
    end
    #2;
    rst_n = 1'b0;
    q.delete();
    #1;
    n_tests++;
    if (obuf_vld !== 1'b0 || obuf_rdy !== 1'b1 || payload_o !== 8'h00) begin
      n_fail++;
      $display("FAIL mr_async got vld=%b rdy=%b pl=%h exp 0 1 00",
               obuf_vld, obuf_rdy, payload_o);
    end
    n_tests++;
    if (arb_gnt !== 5'b00100) begin
      n_fail++;
      $display("FAIL mr_gnt_rst got %b exp 00100", arb_gnt);
    end
    drv_edge();
    rst_n = 1'b1;
    q.push_back(8'hC2);
    @(negedge clk);
    n_tests++;
    if (arb_gnt !== 5'b00100) begin
      n_fail++;
      $display("FAIL mr_gnt1 got %b exp 00100", arb_gnt);
    end
    drv_edge();
    arb_req = 5'b0;
    ds_rdy  = 1'b1;
    @(negedge clk);
    pop_exp();
    n_tests++;
    if (obuf_vld !== 1'b1 || payload_o !== exp_pl) begin
      n_fail++;
      $display("FAIL mr_pl got vld=%b %h exp vld=1 %h",
               obuf_vld, payload_o, exp_pl);
    end
    drv_edge();
    ds_rdy = 1'b0;
    @(negedge clk);
    n_tests++;
    if (obuf_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL mr_empty got %b exp 0", obuf_vld);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_drain();
    test_push_pop();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/obuf_arb.md
OBUF_ARB -- requirements
Module: obuf_arb

Interface
REQ-001 Parameter: PYLD_W, default `PKT_W, payload width in bits.
REQ-002 Parameter: DEPTH, default 2, output FIFO entries; legal values are 2 only.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 arb_req  input  5  per-input-port request toward this output, bit index `DIR_N/`DIR_S/`DIR_E/`DIR_W/`DIR_B.
REQ-006 payload_i  input  5*PYLD_W  per-input-port payload; slice k is bits [k*PYLD_W +: PYLD_W].
REQ-007 arb_gnt  output  5  one-hot or zero grant to input ports.
REQ-008 obuf_rdy  output  1  this output buffer can accept a payload this cycle.
REQ-009 obuf_vld  output  1  payload_o holds valid data for the downstream router.
REQ-010 payload_o  output  PYLD_W  head-of-FIFO payload.
REQ-011 ds_rdy  input  1  downstream input buffer ready.

Function
REQ-012 arb_gnt SHALL be combinational from arb_req and the round-robin pointer ptr (0..4).
REQ-013 arb_gnt SHALL grant the first set arb_req bit searching ptr, ptr+1, ... mod 5.
REQ-014 arb_gnt SHALL be a subset of arb_req; it SHALL be all-zero when arb_req is zero.
REQ-015 arb_gnt SHALL be computed regardless of obuf_rdy, so a requester clears only on arb_gnt & obuf_rdy.
REQ-016 obuf_rdy SHALL be a decode of registered state only: count < 2. It SHALL have no combinational path from ds_rdy or arb_req.
REQ-017 Push SHALL occur when |arb_gnt and obuf_rdy are both high. The payload slice of the granted port SHALL be written at the FIFO tail.
REQ-018 On push from port k, ptr SHALL become (k+1) mod 5 at the next edge. Without a push, ptr SHALL hold.
REQ-019 obuf_vld SHALL equal (count != 0). payload_o SHALL be the head entry.
REQ-020 Pop SHALL occur when obuf_vld and ds_rdy are both high. The head SHALL advance by one entry and wrap mod 2.
REQ-021 Simultaneous push and pop with count=1 SHALL leave count=1. The new entry SHALL become head after the pop.
REQ-022 When count=2, a pop that cycle SHALL NOT enable a push. obuf_rdy is low for that whole cycle, and push resumes next cycle.
REQ-023 Push-to-output latency: an entry pushed into an empty FIFO at edge N SHALL appear with obuf_vld=1 immediately after edge N.
REQ-024 payload_o SHALL hold stable while obuf_vld=1 and ds_rdy=0.
REQ-025 count SHALL never exceed 2 or underflow below 0.

Reset
REQ-026 While rst_n=0: ptr=0, count=0, head and tail pointers = 0, all storage = 0.
REQ-027 While rst_n=0: obuf_vld=0, payload_o=0, obuf_rdy=1.
REQ-028 While rst_n=0: arb_gnt follows REQ-013 with ptr=0.
REQ-029 Reset asserted mid-operation SHALL discard all FIFO contents immediately, with no pop reported.

Verification
REQ-030 Single request: arb_req=5'b00100, payload_i slice 2=0xA5, ds_rdy=1 -> arb_gnt=5'b00100 for one cycle; next cycle obuf_vld=1, payload_o=0xA5; ptr=3.
REQ-031 Round-robin fairness: arb_req=5'b11111 held, ds_rdy=1, ptr=0 -> grants in order ports 0,1,2,3,4,0 on successive cycles.
REQ-032 Backpressure: ds_rdy=0, three requests -> two pushes; count=2; obuf_rdy=0; third arb_gnt stays asserted with no push; payload_o stays equal to the first payload.
REQ-033 Full drain: from count=2, ds_rdy=1 with a request pending -> pop cycle has no push; next cycle push occurs; FIFO order is preserved.
REQ-034 Simultaneous push/pop at count=1 -> count stays 1; payload_o changes to the new entry the next cycle.
REQ-035 Mid-traffic reset: rst_n pulsed low with count=2 -> obuf_vld=0 and obuf_rdy=1 immediately; first grant after release goes to the lowest set arb_req bit (ptr=0).
